lsu_align: RTL
==============

Name: lsu_align

Overview:
Parametrised load/store alignment unit between the execute stage and the synchronous data BRAM. It accepts one memory op per valid/ready handshake and drives byte enables and shifted write data. Load results are extracted and sign/zero-extended. When enabled, accesses that cross a word boundary are split into two BRAM beats. Generalises the old combinational store/load decode to XLEN 32/64, misaligned support, and an explicit response handshake.

Parameters:
XLEN, 32, data/bus width; 32 or 64 only.
ADDR_W, 32, byte-address width.
ALLOW_MISALIGNED, 1, 1 = split boundary-crossing accesses; 0 = return error response.
NB, XLEN/8, bytes per word (derived, localparam).

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
req_valid  in  1  op request.
req_ready  out  1  unit can accept.
req_store  in  1  1 = store, 0 = load.
req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LD/LBU/LHU/LWU, SB/SH/SW/SD).
req_addr  in  ADDR_W  byte address.
req_wdata  in  XLEN  store data, LSB-justified.
mem_en  out  1  BRAM access this cycle.
mem_addr  out  ADDR_W  word-aligned address (low log2(NB) bits zero).
mem_wen  out  NB  byte write enables; all zero for reads.
mem_wdata  out  XLEN  lane-shifted write data.
mem_rdata  in  XLEN  read data, valid the cycle after mem_en.
resp_valid  out  1  response available.
resp_ready  in  1  consumer accepts.
resp_rdata  out  XLEN  extended load result; 0 for stores/errors.
resp_err  out  1  misaligned-disallowed or illegal funct3.

Behaviour:
- Reset: state IDLE. req_ready=1. mem_en=0, mem_wen=0, mem_addr=0, mem_wdata=0. resp_valid=0, resp_rdata=0, resp_err=0. Reset mid-op aborts; a partially issued split store is not completed.
- Size from funct3[1:0]: 1/2/4/8 bytes. Unsigned from funct3[2]. Size 8 or LWU with XLEN=32 is illegal. Store funct3[2]=1 is illegal.
- off = addr mod NB. Split = off + size > NB.
- FSM states: IDLE, BEAT0, BEAT1, CAPT, RESP.
  - IDLE: accept on req_valid&&req_ready; latch request.
    - illegal or (split && !ALLOW_MISALIGNED) -> RESP with err=1; no mem access.
    - otherwise -> BEAT0.
  - BEAT0: mem_en=1, addr = aligned(addr). wen/wdata cover bytes off..min(off+size,NB)-1.
    - split -> BEAT1.
    - else load -> CAPT, store -> RESP.
  - BEAT1: mem_en=1, addr = aligned(addr)+NB. Remaining bytes at lanes 0..off+size-NB-1. Load: capture beat0 rdata this cycle. Next: load -> CAPT, store -> RESP.
  - CAPT: capture last rdata. Merge bytes, extend into resp_rdata register -> RESP.
  - RESP: resp_valid=1 and outputs stable until resp_ready; then -> IDLE.
- req_ready=1 only in IDLE, so there is no back-to-back accept during RESP.
- Latency from accept cycle c0, resp_valid first high at:
  - aligned store c2, split store c3.
  - aligned load c3, split load c4.
  - error c1.
- Little-endian byte order. Extension uses the top byte of the accessed datum.
- mem_en=0 in IDLE/CAPT/RESP. mem_wen=0 whenever mem_en=0 or load.
- Address wrap: aligned(addr)+NB wraps modulo 2^ADDR_W.

Decomposition:
- Package lsu_pkg: funct3 constants, size/extension decode function, state enum.
- Sub-module lsu_lane_shift (combinational byte-lane shifter/extractor), instanced once for write and once for read.

Test Plan:
1. XLEN=32. SB addr 0x101, wdata 0x000000AB -> c1: mem_addr 0x100, mem_wen 0010, mem_wdata 0x0000AB00; c2: resp_valid, err=0.
2. Memory 0x100=0x88776655, 0x104=0xCCBBAA99. LH 0x103 -> beats to 0x100 then 0x104; c4: resp_rdata 0xFFFF9988. LHU same address -> 0x00009988.
3. SW 0x103, data 0x11223344 -> beat0: 0x100, wen 1000, wdata 0x44000000; beat1: 0x104, wen 0111, wdata 0x00112233; c3: resp.
4. ALLOW_MISALIGNED=0, LW 0x102 -> c1: resp_valid=1, resp_err=1, rdata=0; mem_en never asserted. LD with XLEN=32 gives the same error response.
5. Backpressure: hold resp_ready=0 for 5 cycles after LW 0x100 -> resp_valid and rdata 0x88776655 stable; req_ready=0 throughout.
6. Assert rst during BEAT1 of a split store -> next cycle IDLE, req_ready=1, mem_en=0, resp_valid=0.
   Also XLEN=64: LW 0x106 splits, returns the sign-extended word.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and funct3 decode helpers for the load/store alignment unit.
package lsu_pkg;

    localparam logic [2:0] F3Dword = 3'b011;
    localparam logic [2:0] F3WordU = 3'b110;
    localparam logic [2:0] F3Rsvd  = 3'b111;

    typedef enum logic [2:0] {
        StIdle,
        StBeat0,
        StBeat1,
        StCapt,
        StResp
    } lsu_state_e;

    function automatic logic [3:0] f3_nbytes(input logic [2:0] f3);
        return 4'd1 << f3[1:0];
    endfunction

    function automatic logic f3_illegal(input logic store, input logic [2:0] f3,
                                        input int unsigned xlen);
        logic ill;
        ill = store && f3[2];
        if (f3 == F3Rsvd) ill = 1'b1;
        if (xlen == 32 && (f3 == F3Dword || f3 == F3WordU)) ill = 1'b1;
        return ill;
    endfunction

endpackage

// File: rtl/lsu_lane_shift.sv
// Byte-lane shifter: moves data by off_i whole bytes, left for stores, right for loads.
module lsu_lane_shift #(
    parameter int unsigned W    = 64,
    parameter int unsigned OW   = 64,
    parameter int unsigned OffW = 2,
    parameter bit          Left = 1'b1
) (
    input  logic [W-1:0]    data_i,
    input  logic [OffW-1:0] off_i,
    output logic [OW-1:0]   data_o
);

    logic [OffW+2:0] sh;
    assign sh = {off_i, 3'b000};

    if (Left) begin : g_left
        assign data_o = OW'(data_i << sh);
    end else begin : g_right
        assign data_o = OW'(data_i >> sh);
    end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit: one op per handshake, splits word-crossing accesses into two beats.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN             = 32,
    parameter int unsigned ADDR_W           = 32,
    parameter bit          ALLOW_MISALIGNED = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_store,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                mem_en,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN/8-1:0]   mem_wen,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                resp_err
);

    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned OffW = $clog2(NB);
    localparam int unsigned BeW  = 2 * NB;
    localparam int unsigned DW   = 2 * XLEN;

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              store_q, store_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   beat0_q, beat0_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [OffW-1:0]   req_off, off;
    logic [3:0]        req_nbytes, nbytes;
    logic              req_illegal, req_split, split;
    logic [ADDR_W-1:0] aligned;

    assign req_off     = req_addr[OffW-1:0];
    assign req_nbytes  = f3_nbytes(req_funct3);
    assign req_illegal = f3_illegal(req_store, req_funct3, XLEN);
    assign req_split   = (32'(req_off) + 32'(req_nbytes)) > NB;

    assign off     = addr_q[OffW-1:0];
    assign nbytes  = f3_nbytes(f3_q);
    assign split   = (32'(off) + 32'(nbytes)) > NB;
    assign aligned = {addr_q[ADDR_W-1:OffW], {OffW{1'b0}}};

    logic [XLEN-1:0] dmask, sign_bit, wdata_m, rd_val, ext;
    logic [BeW-1:0]  be_full;
    logic [DW-1:0]   wr_in, wr_sh, rd_in;
    logic            sign;

    // Masks are built by shifting; a shift of the full width wraps to all-ones after the -1.
    always_comb begin
        dmask    = (XLEN'(1) << (32'(nbytes) * 8)) - XLEN'(1);
        sign_bit = XLEN'(1) << (32'(nbytes) * 8 - 1);
        be_full  = ((BeW'(1) << nbytes) - BeW'(1)) << off;
        wdata_m  = wdata_q & dmask;
        wr_in    = {{XLEN{1'b0}}, wdata_m};
        rd_in    = split ? {mem_rdata, beat0_q} : {{XLEN{1'b0}}, mem_rdata};
        sign     = !f3_q[2] && |(rd_val & sign_bit);
        ext      = (rd_val & dmask) | (sign ? ~dmask : '0);
    end

    lsu_lane_shift #(
        .W    (DW),
        .OW   (DW),
        .OffW (OffW),
        .Left (1'b1)
    ) u_wr_shift (
        .data_i (wr_in),
        .off_i  (off),
        .data_o (wr_sh)
    );

    lsu_lane_shift #(
        .W    (DW),
        .OW   (XLEN),
        .OffW (OffW),
        .Left (1'b0)
    ) u_rd_shift (
        .data_i (rd_in),
        .off_i  (off),
        .data_o (rd_val)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        store_d    = store_q;
        f3_d       = f3_q;
        wdata_d    = wdata_q;
        beat0_d    = beat0_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        mem_en     = 1'b0;
        mem_addr   = '0;
        mem_wen    = '0;
        mem_wdata  = '0;
        resp_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    store_d = req_store;
                    f3_d    = req_funct3;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = req_illegal || (req_split && !ALLOW_MISALIGNED);
                    state_d = err_d ? StResp : StBeat0;
                end
            end
            StBeat0: begin
                mem_en   = 1'b1;
                mem_addr = aligned;
                if (store_q) begin
                    mem_wen   = be_full[NB-1:0];
                    mem_wdata = wr_sh[XLEN-1:0];
                end
                if (split) state_d = StBeat1;
                else       state_d = store_q ? StResp : StCapt;
            end
            StBeat1: begin
                mem_en   = 1'b1;
                mem_addr = aligned + ADDR_W'(NB);
                if (store_q) begin
                    mem_wen   = be_full[BeW-1:NB];
                    mem_wdata = wr_sh[DW-1:XLEN];
                end else begin
                    beat0_d = mem_rdata;
                end
                state_d = store_q ? StResp : StCapt;
            end
            StCapt: begin
                rdata_d = ext;
                state_d = StResp;
            end
            StResp: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            store_q <= 1'b0;
            f3_q    <= '0;
            wdata_q <= '0;
            beat0_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            f3_q    <= f3_d;
            wdata_q <= wdata_d;
            beat0_q <= beat0_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
